pipe_scroller: RTL and testbench
================================

Name: pipe_scroller

Overview:
- Upstream of the score/display stage. Generates the two scrolling pipe obstacles, "pipe" (slot A) and "ypipe" (slot B).
- Drives the pipe edge coordinates that the pass detector compares against the bird box.
- Moves the pipes left on each game tick, respawns each pipe at the right edge with a pseudo-random gap, and freezes them on game over.
- Single clock domain; movement is gated by a one-cycle game_tick enable.

Parameters:
- SCREEN_W, 640, visible width in pixels
- PIPE_W, 52, pipe width in pixels
- GAP_H, 120, vertical gap height
- GAP_MIN, 60, minimum gap top y
- GAP_SPAN, 241, number of legal gap-top values (128..256)
- SPEED, 2, pixels moved per tick (1..PIPE_W)
- SPACING, 346, horizontal distance at which slot B launches behind A
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
- system_clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- game_tick  in  1  one-cycle movement strobe, synchronous to system_clk
- start  in  1  pulse: begin game (IDLE) or re-arm (FROZEN)
- hit  in  1  pulse: collision/game over
- pipe_high_pic_l, pipe_high_pic_r  out  10  slot A left/right edge
- pipe_high_pic_b  out  10  slot A upper-pipe bottom (gap top)
- pipe_low_pic_t  out  10  slot A lower-pipe top (gap bottom)
- ypipe_high_pic_l, ypipe_high_pic_r, ypipe_high_pic_b, ypipe_low_pic_t  out  10  same fields for slot B
- running  out  1  high in RUN
- spawn  out  2  one-cycle pulse per slot on (re)spawn; bit0 = A, bit1 = B

Behaviour:
- Clock port is system_clk; reset port is reset, asynchronous and active-low.
- While reset is low:
  - FSM = IDLE; both slots parked and inactive; LFSR = LFSR_SEED; spawn = 0; running = 0.
- Parked/inactive slot outputs:
  - r = SCREEN_W+PIPE_W (692), l = SCREEN_W (640), high_b = 0, low_t = 0.
  - A zero-height gap guarantees no false pass downstream.
- Slot state is a 10-bit right edge r. Derived outputs:
  - l = (r > PIPE_W) ? r-PIPE_W : 0 (left edge saturates at screen edge).
  - high_b = gap_top; low_t = gap_top+GAP_H.
- All outputs are registered and update the cycle after the causing event.
- LFSR:
  - 16-bit Galois, taps 0xB400, advances every system_clk in all states except reset.
  - g = lfsr[7:0]; gap_top = GAP_MIN + (g >= GAP_SPAN ? g-GAP_SPAN : g). One conditional subtract suffices because GAP_SPAN >= 128.
  - gap_top is sampled at the spawn instant.
- FSM:
  - IDLE -> RUN on start: slot A spawns (r=692, new gap, spawn[0]); slot B stays parked.
  - RUN, game_tick, no hit, for each active slot:
    - if r <= SPEED: respawn at r=692 with a new gap, pulse spawn bit;
    - else r -= SPEED.
  - RUN, B launch: on the tick where A is active, B inactive, and A's updated l <= SCREEN_W-SPACING (294), B spawns (spawn[1]).
  - After B launches, both slots free-run independently; spacing is preserved by identical speed and respawn point.
  - RUN -> FROZEN on hit: positions and gaps hold; game_tick ignored.
  - FROZEN -> IDLE on start: both slots park. A further start is required to run.
- Priorities:
  - hit beats game_tick and start in the same cycle (no movement that cycle).
  - start in RUN is ignored.
  - hit in IDLE is ignored.
- Both slots respawning on the same tick: both draw the same gap_top (legal, no special handling).
- Reset low mid-operation: immediate return to reset values regardless of state.

Decomposition:
- flappy_defs.vh: SCREEN_W, SCREEN_H (480), PIPE_W, GAP_H, GAP_MIN, GAP_SPAN, FSM state encodings (IDLE=2'd0, RUN=2'd1, FROZEN=2'd2); shared with bird and scorer blocks.
- Sub-module pipe_slot, instantiated twice, holding r, gap_top and the active flag.
  - Inputs: step, spawn_req, park, gap_in.
  - Outputs: l, r, high_b, low_t, wrapped.
- FSM, LFSR and launch logic live in pipe_scroller.

Test Plan:
- Reset, then release with no start -> both slots l=640, r=692, high_b=0, low_t=0; running=0; spawn=0 for 100 ticks.
- start, then one game_tick -> spawn=01 the cycle after start; A r=690, l=638; gap_top in [60,300] and low_t = gap_top+120; B still parked.
- Run 173 ticks -> A l reaches 294 on tick 173; spawn[1] pulses exactly once; B r=692. At r=52 -> l=0; at r=50 -> l=0.
- Run until A r=2, then one tick -> A r=692, new gap, spawn[0] pulses; B keeps moving by 2 on the same tick.
- hit asserted in the same cycle as game_tick -> no position change; running=0; all further ticks ignored. start -> all parked; second start -> A spawns.
- Reset low mid-RUN with A at r=400 -> outputs at parked values asynchronously. Over 10k spawns, every gap_top lies in [60,300] and every value is observed.

Source files
------------

// File: rtl/pipe_scroller_pkg.sv
// Shared geometry, gap and FSM definitions for the pipe obstacle generator.
package pipe_scroller_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned PIPE_W_DEF   = 52;
  localparam int unsigned GAP_H_DEF    = 120;
  localparam int unsigned GAP_MIN_DEF  = 60;
  localparam int unsigned GAP_SPAN_DEF = 241;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  // 16-bit Galois LFSR, taps 0xB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ ({16{s[0]}} & 16'hB400);
  endfunction

endpackage

// File: rtl/pipe_scroller_slot.sv
// One pipe obstacle slot: right edge, gap and active flag, with registered edges.
module pipe_slot
  import pipe_scroller_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned PIPE_W   = PIPE_W_DEF,
  parameter int unsigned GAP_H    = GAP_H_DEF,
  parameter int unsigned SPEED    = 2
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       step,
  input  logic       spawn_req,
  input  logic       park,
  input  logic [9:0] gap_in,
  output logic [9:0] l,
  output logic [9:0] r,
  output logic [9:0] high_b,
  output logic [9:0] low_t,
  output logic       active,
  output logic       wrapped
);

  localparam logic [9:0] R_SPAWN = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] L_PARK  = 10'(SCREEN_W);

  logic [9:0] r_nxt, l_nxt, b_nxt, t_nxt;
  logic       act_nxt;

  // Asserted when the next step would carry the slot off the left edge.
  assign wrapped = active && (r <= 10'(SPEED));

  always_comb begin
    r_nxt   = r;
    b_nxt   = high_b;
    t_nxt   = low_t;
    act_nxt = active;
    if (park) begin
      r_nxt   = R_SPAWN;
      b_nxt   = '0;
      t_nxt   = '0;
      act_nxt = 1'b0;
    end else if (spawn_req || (step && wrapped)) begin
      r_nxt   = R_SPAWN;
      b_nxt   = gap_in;
      t_nxt   = gap_in + 10'(GAP_H);
      act_nxt = 1'b1;
    end else if (step && active) begin
      r_nxt = r - 10'(SPEED);
    end
    l_nxt = (r_nxt > 10'(PIPE_W)) ? r_nxt - 10'(PIPE_W) : '0;
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r      <= R_SPAWN;
      l      <= L_PARK;
      high_b <= '0;
      low_t  <= '0;
      active <= 1'b0;
    end else begin
      r      <= r_nxt;
      l      <= l_nxt;
      high_b <= b_nxt;
      low_t  <= t_nxt;
      active <= act_nxt;
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Two scrolling pipe obstacles with pseudo-random gaps, game FSM and B-slot launch.
module pipe_scroller
  import pipe_scroller_pkg::*;
#(
  parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
  parameter int unsigned PIPE_W    = PIPE_W_DEF,
  parameter int unsigned GAP_H     = GAP_H_DEF,
  parameter int unsigned GAP_MIN   = GAP_MIN_DEF,
  parameter int unsigned GAP_SPAN  = GAP_SPAN_DEF,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned SPACING   = 346,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       game_tick,
  input  logic       start,
  input  logic       hit,
  output logic [9:0] pipe_high_pic_l,
  output logic [9:0] pipe_high_pic_r,
  output logic [9:0] pipe_high_pic_b,
  output logic [9:0] pipe_low_pic_t,
  output logic [9:0] ypipe_high_pic_l,
  output logic [9:0] ypipe_high_pic_r,
  output logic [9:0] ypipe_high_pic_b,
  output logic [9:0] ypipe_low_pic_t,
  output logic       running,
  output logic [1:0] spawn
);

  localparam logic [9:0] LAUNCH_L = 10'(SCREEN_W - SPACING);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [9:0]  g10, gap_top;
  logic [9:0]  a_step_r, a_step_l;
  logic        a_active, b_active, a_wrapped, b_wrapped;
  logic        a_spawn, b_spawn, park, step, launch;

  // GAP_SPAN >= 128 so one conditional subtract folds 0..255 into range.
  assign g10     = {2'b00, lfsr[7:0]};
  assign gap_top = 10'(GAP_MIN) + ((g10 >= 10'(GAP_SPAN)) ? g10 - 10'(GAP_SPAN) : g10);

  assign a_step_r = pipe_high_pic_r - 10'(SPEED);
  assign a_step_l = (a_step_r > 10'(PIPE_W)) ? a_step_r - 10'(PIPE_W) : '0;
  assign launch   = a_active && !b_active && !a_wrapped && (a_step_l <= LAUNCH_L);

  assign running = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    a_spawn   = 1'b0;
    b_spawn   = 1'b0;
    park      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          a_spawn   = 1'b1;
        end
      end
      ST_RUN: begin
        if (hit) begin
          state_nxt = ST_FROZEN;
        end else if (game_tick) begin
          step    = 1'b1;
          b_spawn = launch;
        end
      end
      ST_FROZEN: begin
        if (start) begin
          state_nxt = ST_IDLE;
          park      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      lfsr  <= LFSR_SEED;
      spawn <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_step(lfsr);
      spawn <= {b_spawn | (step & b_wrapped), a_spawn | (step & a_wrapped)};
    end
  end

  pipe_slot #(
    .SCREEN_W(SCREEN_W),
    .PIPE_W  (PIPE_W),
    .GAP_H   (GAP_H),
    .SPEED   (SPEED)
  ) u_slot_a (
    .system_clk(system_clk),
    .reset     (reset),
    .step      (step),
    .spawn_req (a_spawn),
    .park      (park),
    .gap_in    (gap_top),
    .l         (pipe_high_pic_l),
    .r         (pipe_high_pic_r),
    .high_b    (pipe_high_pic_b),
    .low_t     (pipe_low_pic_t),
    .active    (a_active),
    .wrapped   (a_wrapped)
  );

  pipe_slot #(
    .SCREEN_W(SCREEN_W),
    .PIPE_W  (PIPE_W),
    .GAP_H   (GAP_H),
    .SPEED   (SPEED)
  ) u_slot_b (
    .system_clk(system_clk),
    .reset     (reset),
    .step      (step),
    .spawn_req (b_spawn),
    .park      (park),
    .gap_in    (gap_top),
    .l         (ypipe_high_pic_l),
    .r         (ypipe_high_pic_r),
    .high_b    (ypipe_high_pic_b),
    .low_t     (ypipe_low_pic_t),
    .active    (b_active),
    .wrapped   (b_wrapped)
  );

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller against a cycle-level behavioural model.
module tb_pipe_scroller;

  localparam int PARK_R = 692;
  localparam int PARK_L = 640;

  logic       system_clk = 1'b0;
  logic       reset = 1'b0;
  logic       game_tick = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] pipe_high_pic_l, pipe_high_pic_r, pipe_high_pic_b, pipe_low_pic_t;
  logic [9:0] ypipe_high_pic_l, ypipe_high_pic_r, ypipe_high_pic_b, ypipe_low_pic_t;
  logic       running;
  logic [1:0] spawn;

  int checks = 0;
  int errors = 0;

  pipe_scroller #(
    .SPEED    (2),
    .SPACING  (346),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .system_clk      (system_clk),
    .reset           (reset),
    .game_tick       (game_tick),
    .start           (start),
    .hit             (hit),
    .pipe_high_pic_l (pipe_high_pic_l),
    .pipe_high_pic_r (pipe_high_pic_r),
    .pipe_high_pic_b (pipe_high_pic_b),
    .pipe_low_pic_t  (pipe_low_pic_t),
    .ypipe_high_pic_l(ypipe_high_pic_l),
    .ypipe_high_pic_r(ypipe_high_pic_r),
    .ypipe_high_pic_b(ypipe_high_pic_b),
    .ypipe_low_pic_t (ypipe_low_pic_t),
    .running         (running),
    .spawn           (spawn)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    int l[2];
    int r[2];
    int b[2];
    int t[2];
    int run;
    int sp;
  } exp_t;

  exp_t q[$];

  // Behavioural model: mode 0 idle, 1 running, 2 frozen.
  int m_mode;
  int m_lfsr;
  int m_r[2];
  int m_gap[2];
  bit m_act[2];
  int m_sp;

  function automatic int gap_of(input int x);
    int g;
    g = x % 256;
    return 60 + ((g >= 241) ? g - 241 : g);
  endfunction

  function automatic int left_of(input int r);
    return (r > 52) ? r - 52 : 0;
  endfunction

  task automatic park_all();
    for (int s = 0; s < 2; s++) begin
      m_r[s] = PARK_R; m_gap[s] = 0; m_act[s] = 0;
    end
  endtask

  task automatic put(input int s, input int g);
    m_r[s] = PARK_R; m_gap[s] = g; m_act[s] = 1; m_sp += (1 << s);
  endtask

  always @(posedge system_clk) begin
    exp_t e;
    int   gap;
    if (!reset) begin
      m_mode = 0; m_lfsr = 16'hACE1; m_sp = 0;
      park_all();
    end else begin
      gap    = gap_of(m_lfsr);
      m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 16'hB400 : 0);
      m_sp   = 0;
      case (m_mode)
        0: if (start) begin m_mode = 1; put(0, gap); end
        1: begin
          if (hit) m_mode = 2;
          else if (game_tick) begin
            bit b_was_active;
            b_was_active = m_act[1];
            for (int s = 0; s < 2; s++) begin
              if (m_act[s]) begin
                if (m_r[s] <= 2) put(s, gap);
                else m_r[s] -= 2;
              end
            end
            if (m_act[0] && !b_was_active && left_of(m_r[0]) <= 294) put(1, gap);
          end
        end
        default: if (start) begin m_mode = 0; park_all(); end
      endcase
    end
    for (int s = 0; s < 2; s++) begin
      e.r[s] = m_r[s];
      e.l[s] = m_act[s] ? left_of(m_r[s]) : PARK_L;
      e.b[s] = m_gap[s];
      e.t[s] = m_act[s] ? m_gap[s] + 120 : 0;
    end
    e.run = (m_mode == 1) ? 1 : 0;
    e.sp  = m_sp;
    q.push_back(e);
  end

  bit seen[241];
  int cyc = 0;

  always @(posedge system_clk) begin
    exp_t e;
    int   bv[2];
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (pipe_high_pic_l != e.l[0] || pipe_high_pic_r != e.r[0] ||
          pipe_high_pic_b != e.b[0] || pipe_low_pic_t != e.t[0] ||
          ypipe_high_pic_l != e.l[1] || ypipe_high_pic_r != e.r[1] ||
          ypipe_high_pic_b != e.b[1] || ypipe_low_pic_t != e.t[1] ||
          running != e.run[0] || spawn != e.sp[1:0]) begin
        errors++;
        $display("FAIL outputs cyc %0d: got A l/r/b/t=%0d/%0d/%0d/%0d B=%0d/%0d/%0d/%0d run=%0d spawn=%0d; need A=%0d/%0d/%0d/%0d B=%0d/%0d/%0d/%0d run=%0d spawn=%0d",
                 cyc, pipe_high_pic_l, pipe_high_pic_r, pipe_high_pic_b, pipe_low_pic_t,
                 ypipe_high_pic_l, ypipe_high_pic_r, ypipe_high_pic_b, ypipe_low_pic_t,
                 running, spawn, e.l[0], e.r[0], e.b[0], e.t[0],
                 e.l[1], e.r[1], e.b[1], e.t[1], e.run, e.sp);
      end
    end
    bv[0] = int'(pipe_high_pic_b);
    bv[1] = int'(ypipe_high_pic_b);
    for (int s = 0; s < 2; s++) begin
      if (reset && spawn[s]) begin
        checks++;
        if (bv[s] < 60 || bv[s] > 300) begin
          errors++;
          $display("FAIL gap_range slot%0d: got %0d, need 60..300", s, bv[s]);
        end else begin
          seen[bv[s] - 60] = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit st, input bit ht, input bit tk);
    @(negedge system_clk);
    start = st; hit = ht; game_tick = tk;
  endtask

  initial begin
    int n;
    int nseen;
    repeat (3) @(negedge system_clk);
    reset = 1'b1;

    // Idle: ticks and hits must not disturb the parked slots.
    repeat (100) drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // First run: launch of B, A wrap, start ignored while running.
    drive(1, 0, 0);
    drive(0, 0, 1);
    repeat (700) drive(1'($urandom_range(0, 15) == 0), 0, 1'($urandom_range(0, 3) != 0));

    // Hit together with a tick freezes; ticks ignored; start parks; start again runs.
    drive(0, 1, 1);
    repeat (20) drive(0, 1'($urandom_range(0, 1)), 1);
    drive(1, 0, 1);
    drive(0, 0, 1);
    drive(1, 0, 0);
    repeat (10) drive(0, 0, 1);

    // Async reset mid-run with A at r=400.
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    n = 0;
    while (m_r[0] != 400 && n < 1000) begin
      @(negedge system_clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL reach_r400: got r=%0d after %0d cycles, need 400", m_r[0], n);
    end
    game_tick = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (pipe_high_pic_l != 10'd640 || pipe_high_pic_r != 10'd692 || pipe_high_pic_b != 10'd0 ||
        pipe_low_pic_t != 10'd0 || ypipe_high_pic_r != 10'd692 || running != 1'b0 || spawn != 2'b00) begin
      errors++;
      $display("FAIL async_reset: got A l=%0d r=%0d b=%0d t=%0d Br=%0d run=%0d spawn=%0d, need 640/692/0/0 692 0 0",
               pipe_high_pic_l, pipe_high_pic_r, pipe_high_pic_b, pipe_low_pic_t,
               ypipe_high_pic_r, running, spawn);
    end
    repeat (2) @(negedge system_clk);
    reset = 1'b1;

    // Many short games to sweep the gap distribution.
    repeat (4000) begin
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive(1'($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 1)));
      drive(0, 1, 1'($urandom_range(0, 1)));
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive(0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge system_clk);
    end
    repeat (4) @(negedge system_clk);

    nseen = 0;
    for (int i = 0; i < 241; i++) if (seen[i]) nseen++;
    checks++;
    if (nseen != 241) begin
      errors++;
      $display("FAIL gap_coverage: got %0d distinct gap values, need 241", nseen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
